// File: rtl/dma_pkg.sv
// Shared types and default widths for the dma_copy block-move engine.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

  localparam int DMA_AW = 8;
  localparam int DMA_DW = 8;

endpackage

// File: rtl/dma_copy.sv
// Byte-block copy engine that owns the data memory port while busy.
// Optional constant fill mode is enabled with DMA_COPY_FILL_EN.
module dma_copy
  import dma_pkg::*;
#(
  parameter int AW = DMA_AW,
  parameter int DW = DMA_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
`ifdef DMA_COPY_FILL_EN
  input  logic          fill,
  input  logic [DW-1:0] fill_val,
`endif
  input  logic [DW-1:0] mem_dat_out,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  output logic          mem_wr_en,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_READ  = READ;
  localparam logic [1:0] S_WRITE = WRITE;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]    state_q,   state_d;
  logic [AW-1:0] src_ptr_q, src_ptr_d;
  logic [AW-1:0] dst_ptr_q, dst_ptr_d;
  logic [AW-1:0] remaining_q, remaining_d;
  logic [DW-1:0] buf_q,     buf_d;
`ifdef DMA_COPY_FILL_EN
  logic          fill_q,    fill_d;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    buf_d       = buf_q;
`ifdef DMA_COPY_FILL_EN
    fill_d      = fill_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_ptr_d   = src;
          dst_ptr_d   = dst;
          remaining_d = len;
`ifdef DMA_COPY_FILL_EN
          fill_d      = fill;
          if (len == '0) begin
            state_d = S_DONE;
          end else if (fill) begin
            buf_d   = fill_val;
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
`else
          state_d = (len == '0) ? S_DONE : S_READ;
`endif
        end
      end
      S_READ: begin
        buf_d     = mem_dat_out;
        src_ptr_d = src_ptr_q + 1'b1;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        dst_ptr_d   = dst_ptr_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == AW'(1)) begin
          state_d = S_DONE;
        end else begin
`ifdef DMA_COPY_FILL_EN
          state_d = fill_q ? S_WRITE : S_READ;
`else
          state_d = S_READ;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: decoded only from registered state, never from start.
  always_comb begin
    mem_addr   = '0;
    mem_dat_in = '0;
    mem_wr_en  = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    case (state_q)
      S_READ:  mem_addr = src_ptr_q;
      S_WRITE: begin
        mem_addr   = dst_ptr_q;
        mem_dat_in = buf_q;
        mem_wr_en  = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge values, matching real hardware regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      buf_q       <= '0;
`ifdef DMA_COPY_FILL_EN
      fill_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      buf_q       <= buf_d;
`ifdef DMA_COPY_FILL_EN
      fill_q      <= fill_d;
`endif
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: behavioural 256-byte memory plus timing/content checks.
module tb_dma_copy;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] src, dst, len;
  logic [7:0] mem_dat_out, mem_addr, mem_dat_in;
  logic       mem_wr_en, busy, done;
`ifdef DMA_COPY_FILL_EN
  logic       fill;
  logic [7:0] fill_val;
`endif

  logic [7:0] mem [256];
  logic       tb_we;
  logic [7:0] tb_addr, tb_wdat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dma_copy dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src        (src),
    .dst        (dst),
    .len        (len),
`ifdef DMA_COPY_FILL_EN
    .fill       (fill),
    .fill_val   (fill_val),
`endif
    .mem_dat_out(mem_dat_out),
    .mem_addr   (mem_addr),
    .mem_dat_in (mem_dat_in),
    .mem_wr_en  (mem_wr_en),
    .busy       (busy),
    .done       (done)
  );

  assign mem_dat_out = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en)  mem[mem_addr] <= mem_dat_in;
    else if (tb_we) mem[tb_addr]  <= tb_wdat;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] v);
    tb_we = 1'b1; tb_addr = a; tb_wdat = v;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // Drive a start pulse sampled at the next edge (edge 0 of the transfer).
  task automatic kick(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    src = s; dst = d; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Watch cycles 1.. until one cycle past done; optionally pulse a stray start.
  task automatic monitor(input string tag, input int exp_done, input int exp_wr, input int poke_cyc);
    int dcyc = 0, bcnt = 0, wcnt = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (cyc == poke_cyc) begin
        src = 8'd40; dst = 8'd52; len = 8'd1; start = 1'b1;
      end else if (cyc == poke_cyc + 1) begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      if (mem_wr_en) wcnt++;
      if (done && dcyc == 0) dcyc = cyc;
      if (dcyc != 0 && cyc == dcyc + 1) break;
    end
    chk({tag, "_done_cyc"}, dcyc, exp_done);
    chk({tag, "_busy_cyc"}, bcnt, exp_done);
    chk({tag, "_wr_cnt"}, wcnt, exp_wr);
  endtask

  initial begin
    int dsaw;
    reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    tb_we = 1'b0; tb_addr = '0; tb_wdat = '0;
`ifdef DMA_COPY_FILL_EN
    fill = 1'b0; fill_val = '0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_wdat", mem_dat_in, 8'h00);
    chk("rst_wr", mem_wr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    // Basic copy of 4 bytes.
    preload(8'd10, 8'hA1); preload(8'd11, 8'hA2);
    preload(8'd12, 8'hA3); preload(8'd13, 8'hA4);
    preload(8'd104, 8'hEE);
    kick(8'd10, 8'd100, 8'd4);
    monitor("cp4", 9, 4, 0);
    chk("cp4_m100", mem[100], 8'hA1);
    chk("cp4_m101", mem[101], 8'hA2);
    chk("cp4_m102", mem[102], 8'hA3);
    chk("cp4_m103", mem[103], 8'hA4);
    chk("cp4_m104", mem[104], 8'hEE);

    // Zero length: done in cycle 1, no memory access.
    preload(8'd6, 8'hC6);
    kick(8'd5, 8'd6, 8'd0);
    monitor("len0", 1, 0, 0);
    chk("len0_m6", mem[6], 8'hC6);

    // Source wrap, then destination wrap (back-to-back starts).
    preload(8'd254, 8'h11); preload(8'd255, 8'h22);
    preload(8'd0, 8'h33); preload(8'd1, 8'h44); preload(8'd2, 8'h55);
    kick(8'd254, 8'd126, 8'd3);
    monitor("wrs", 7, 3, 0);
    kick(8'd0, 8'd254, 8'd3);
    monitor("wrd", 7, 3, 0);
    chk("wrs_m126", mem[126], 8'h11);
    chk("wrs_m127", mem[127], 8'h22);
    chk("wrs_m128", mem[128], 8'h33);
    chk("wrd_m254", mem[254], 8'h33);
    chk("wrd_m255", mem[255], 8'h44);
    chk("wrd_m0", mem[0], 8'h55);

    // Overlapping forward copy replicates the first byte.
    preload(8'd20, 8'h07); preload(8'd21, 8'h09);
    preload(8'd22, 8'h00); preload(8'd23, 8'h00);
    kick(8'd20, 8'd21, 8'd3);
    monitor("ovl", 7, 3, 0);
    chk("ovl_m21", mem[21], 8'h07);
    chk("ovl_m22", mem[22], 8'h07);
    chk("ovl_m23", mem[23], 8'h07);

    // Stray start in cycle 3 of a running copy is ignored.
    preload(8'd40, 8'hC1); preload(8'd41, 8'hC2); preload(8'd52, 8'h66);
    kick(8'd40, 8'd50, 8'd2);
    monitor("ign", 5, 2, 3);
    chk("ign_m50", mem[50], 8'hC1);
    chk("ign_m51", mem[51], 8'hC2);
    chk("ign_m52", mem[52], 8'h66);

    // Reset during the second WRITE of a 4-byte copy.
    preload(8'd30, 8'hD0); preload(8'd31, 8'hD1);
    preload(8'd32, 8'hD2); preload(8'd33, 8'hD3);
    preload(8'd60, 8'h00); preload(8'd61, 8'h00);
    preload(8'd62, 8'h00); preload(8'd63, 8'h00);
    kick(8'd30, 8'd60, 8'd4);
    repeat (4) @(negedge clk);
    chk("rmid_wr_before", mem_wr_en, 1'b1);
    chk("rmid_addr_before", mem_addr, 8'd61);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    dsaw = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dsaw = 1;
      if (i == 0) begin
        chk("rmid_busy_after", busy, 1'b0);
        chk("rmid_wr_after", mem_wr_en, 1'b0);
      end
    end
    chk("rmid_no_done", dsaw, 0);
    chk("rmid_m60", mem[60], 8'hD0);
    chk("rmid_m61", mem[61], 8'hD1);
    chk("rmid_m62", mem[62], 8'h00);
    chk("rmid_m63", mem[63], 8'h00);
    kick(8'd30, 8'd60, 8'd4);
    monitor("rmid_redo", 9, 4, 0);
    chk("rmid_redo_m62", mem[62], 8'hD2);
    chk("rmid_redo_m63", mem[63], 8'hD3);

`ifdef DMA_COPY_FILL_EN
    // Fill mode: one cycle per byte, src ignored.
    preload(8'd203, 8'h77);
    fill = 1'b1; fill_val = 8'h5A;
    kick(8'd13, 8'd200, 8'd3);
    fill = 1'b0; fill_val = 8'h00;
    monitor("fill", 4, 3, 0);
    chk("fill_m200", mem[200], 8'h5A);
    chk("fill_m201", mem[201], 8'h5A);
    chk("fill_m202", mem[202], 8'h5A);
    chk("fill_m203", mem[203], 8'h77);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_copy.md
Name: dma_copy

Overview:
- Memory-side initiator that moves a block of bytes within the 256-byte data memory.
- While busy it owns the memory's single port: it drives the address, write data and write enable, and consumes the combinational read data.
- The core starts a transfer with a one-cycle start pulse and waits for done.
- Top level muxes the memory port between core and dma_copy using busy.

Parameters:
AW, 8, address width; memory depth is 2**AW.
DW, 8, data width.

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a transfer
src  input  AW  first source address, sampled on accepted start
dst  input  AW  first destination address, sampled on accepted start
len  input  AW  byte count, sampled on accepted start; 0 means no transfer
mem_dat_out  input  DW  combinational read data from memory at mem_addr
mem_addr  output  AW  memory address pointer
mem_dat_in  output  DW  memory write data
mem_wr_en  output  1  memory write enable
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE; mem_addr=0, mem_dat_in=0, mem_wr_en=0, busy=0, done=0; internal src_ptr, dst_ptr, remaining and buf all 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Outputs are driven at their reset values.
  - start=1 latches src, dst and len.
  - If len≠0, go to READ; if len=0, go to DONE with no memory access.
- READ:
  - mem_addr=src_ptr, mem_wr_en=0.
  - At the edge, buf<=mem_dat_out, src_ptr<=src_ptr+1, then go to WRITE.
- WRITE:
  - mem_addr=dst_ptr, mem_dat_in=buf, mem_wr_en=1.
  - At the edge, dst_ptr<=dst_ptr+1 and remaining<=remaining-1.
  - If remaining==1, go to DONE; otherwise go to READ.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
- Latency:
  - Start sampled at edge 0. READ occupies cycle 1 and WRITE cycle 2; each byte takes 2 cycles.
  - done is high during cycle 2N+1 for len=N.
  - len=0 gives done in cycle 1.
  - Back-to-back transfers are possible: a new start is accepted in the first IDLE cycle after DONE.
- start while busy is ignored; there is no queueing.
- Pointer arithmetic is modulo 2**AW. Address 255+1 wraps to 0 for both src and dst.
- Overlap: forward byte-by-byte copy. When dst lies inside (src, src+len) the result is defined: earlier-written bytes get re-read, replicating the pattern. The bench checks this.
- src==dst is legal: memory contents are unchanged, and timing still follows the normal 2-cycles-per-byte rule.
- Reset asserted mid-transfer:
  - Next edge forces IDLE.
  - mem_wr_en is low from that cycle onward.
  - Bytes already written stay written; done is not pulsed.
- Outputs are registered-state decoded (Moore). There is no combinational path from start to mem_* outputs.

Optional Feature:
Macro DMA_COPY_FILL_EN.
- Defined:
  - Adds input fill (1 bit) and input fill_val (DW).
  - If fill=1 on an accepted start, the block skips READ: IDLE goes to WRITE with buf<=fill_val, and WRITE loops to WRITE.
  - A fill costs 1 cycle per byte; done is in cycle N+1.
  - src is ignored during a fill.
- Undefined: the ports do not exist, and all transfers are copies.

Decomposition:
- Package dma_pkg holds:
  - typedef enum logic[1:0] dma_state_t {IDLE, READ, WRITE, DONE};
  - localparams DMA_AW=8 and DMA_DW=8.
- No sub-module: the FSM, the two pointers and the counter fit in one module.
- Port muxing with the core lives in the top level, not in dma_copy.

Test Plan:
- Preload mem[10..13]=8'hA1..A4; start src=10, dst=100, len=4 → mem[100..103]=A1..A4; done in cycle 9; busy cycles 1–9; mem[104] unchanged.
- len=0, src=5, dst=6 → done in cycle 1; mem_wr_en never high; mem[6] unchanged.
- Wrap case: preload mem[254]=11, mem[255]=22, mem[0]=33; start src=254, dst=126, len=3 → mem[126..128]=11,22,33. Then src=0, dst=254, len=3 → writes land on mem[254], mem[255], mem[0].
- Overlap case: mem[20]=7, mem[21]=9; start src=20, dst=21, len=3 → mem[21..23]=7,7,7.
- Reset mid-operation: assert reset for 1 cycle during the second WRITE of a len=4 copy → only the first 2 destination bytes are updated; done never pulses; busy is 0 after reset; a new start then completes normally. Also pulse start at cycle 3 of a running copy → ignored; the copy completes unaltered.
- With DMA_COPY_FILL_EN defined: fill=1, fill_val=8'h5A, dst=200, len=3 → mem[200..202]=5A; done in cycle 4.
